// File: rtl/pipelined_control_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pipelined_control_unit
//
// RV32I/M control unit for the pipelined core. Decodes the ID-stage
// instruction, registers all control into the ID/EX control register, resolves
// conditional branches in EX from the ALU zero flag, and stalls ID while a
// multi-cycle MUL/DIV operation is in flight. Illegal encodings are carried
// down the pipe as a flagged, side-effect-free slot.
//
// Ports
//   clk       in   core clock
//   rst       in   asynchronous active-high reset
//   id_valid  in   ID-stage instruction valid
//   opcode    in   instr[6:0]
//   funct3    in   instr[14:12]
//   funct7    in   instr[31:25]
//   flush     in   squash ID/EX (taken branch/jump upstream), highest priority
//   z         in   EX-stage ALU zero flag
//   id_ready  out  ID may advance (not stalled)            -- combinational
//   ex_valid  out  ID/EX holds a live instruction           -- registered
//   aluc      out  ALU operation code                       -- registered
//   ctrl      out  {mem2reg,wmem,aluimm,wreg,jal,jalr,
//                   signext,auipc,ls_b,ls_h,load_signext}   -- registered
//   pcsrc     out  00 seq, 01 branch taken, 10 jal, 11 jalr -- combinational
//   md_start  out  one-cycle launch pulse for the mul/div unit
//   md_busy   out  mul/div sequencer is stalling the pipe
//   illegal   out  ID/EX holds an illegal encoding
// -----------------------------------------------------------------------------
module pipelined_control_unit #(
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        flush,
    input  logic        z,
    output logic        id_ready,
    output logic        ex_valid,
    output logic [5:0]  aluc,
    output logic [10:0] ctrl,
    output logic [1:0]  pcsrc,
    output logic        md_start,
    output logic        md_busy,
    output logic        illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // Bit positions inside ctrl.
    localparam int C_MEM2REG = 10;
    localparam int C_WMEM    = 9;
    localparam int C_ALUIMM  = 8;
    localparam int C_WREG    = 7;
    localparam int C_JAL     = 6;
    localparam int C_JALR    = 5;
    localparam int C_SIGNEXT = 4;
    localparam int C_AUIPC   = 3;
    localparam int C_LSB     = 2;
    localparam int C_LSH     = 1;
    localparam int C_LSE     = 0;

    localparam logic [5:0] ALUC_ADD = 6'b000000;
    localparam logic [5:0] ALUC_SUB = 6'b001000;
    localparam logic [5:0] ALUC_LUI = 6'b000010;

    // Busy-cycle counts loaded on launch; the launch cycle itself is one of the
    // LAT cycles, so only LAT-1 stall cycles follow.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MD_BUSY = 1'b1
    } state_t;

    // Base integer ops: {funct3[2:1], alt, funct3[0], 00}. Bit 0 is never set,
    // which keeps these codes disjoint from the M-extension codes below.
    function automatic logic [5:0] alu_base(input logic [2:0] f3, input logic alt);
        return {f3[2:1], alt, f3[0], 2'b00};
    endfunction

    // M-extension ops: {funct3[1:0], funct3[2], 00, 1}; mul=000001, div=001001.
    function automatic logic [5:0] alu_mext(input logic [2:0] f3);
        return {f3[1:0], f3[2], 2'b00, 1'b1};
    endfunction

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic        dec_legal;
    logic [5:0]  dec_aluc_raw;
    logic [10:0] dec_ctrl_raw;
    logic        dec_branch_raw;
    logic        dec_mop_raw;
    logic [5:0]  dec_aluc;
    logic [10:0] dec_ctrl;
    logic        dec_branch;
    logic        dec_mop;

    always_comb begin
        dec_legal      = 1'b0;
        dec_aluc_raw   = ALUC_ADD;
        dec_ctrl_raw   = '0;
        dec_branch_raw = 1'b0;
        dec_mop_raw    = 1'b0;
        unique case (opcode)
            OP_R: begin
                dec_ctrl_raw[C_WREG]    = 1'b1;
                dec_ctrl_raw[C_SIGNEXT] = 1'b1;
                if (funct7 == F7_BASE) begin
                    dec_legal    = 1'b1;
                    dec_aluc_raw = alu_base(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_legal    = 1'b1;
                    dec_aluc_raw = alu_base(funct3, 1'b1);
                end else if (funct7 == F7_MEXT && ENABLE_M != 0) begin
                    dec_legal    = 1'b1;
                    dec_mop_raw  = 1'b1;
                    dec_aluc_raw = alu_mext(funct3);
                end
            end
            OP_IMM: begin
                dec_ctrl_raw[C_ALUIMM]  = 1'b1;
                dec_ctrl_raw[C_WREG]    = 1'b1;
                dec_ctrl_raw[C_SIGNEXT] = 1'b1;
                // Shift-immediates carry funct7 in imm[11:5]; only slli/srli/srai exist.
                if (funct3 == 3'b001) begin
                    dec_legal    = (funct7 == F7_BASE);
                    dec_aluc_raw = alu_base(funct3, 1'b0);
                end else if (funct3 == 3'b101) begin
                    dec_legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    dec_aluc_raw = alu_base(funct3, funct7[5]);
                end else begin
                    dec_legal    = 1'b1;
                    dec_aluc_raw = alu_base(funct3, 1'b0);
                end
            end
            OP_LOAD: begin
                dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                            (funct3 == 3'b100) || (funct3 == 3'b101);
                dec_ctrl_raw[C_MEM2REG] = 1'b1;
                dec_ctrl_raw[C_ALUIMM]  = 1'b1;
                dec_ctrl_raw[C_WREG]    = 1'b1;
                dec_ctrl_raw[C_SIGNEXT] = 1'b1;
                dec_ctrl_raw[C_LSB]     = (funct3[1:0] == 2'b00);
                dec_ctrl_raw[C_LSH]     = (funct3[1:0] == 2'b01);
                // Sign-extension only matters for sub-word loads (lb/lh).
                dec_ctrl_raw[C_LSE]     = ~funct3[2] & ~funct3[1];
            end
            OP_STORE: begin
                dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
                dec_ctrl_raw[C_WMEM]    = 1'b1;
                dec_ctrl_raw[C_ALUIMM]  = 1'b1;
                dec_ctrl_raw[C_SIGNEXT] = 1'b1;
                dec_ctrl_raw[C_LSB]     = (funct3[1:0] == 2'b00);
                dec_ctrl_raw[C_LSH]     = (funct3[1:0] == 2'b01);
            end
            OP_BRANCH: begin
                dec_legal      = (funct3 != 3'b010) && (funct3 != 3'b011);
                dec_aluc_raw   = ALUC_SUB;
                dec_branch_raw = 1'b1;
                dec_ctrl_raw[C_SIGNEXT] = 1'b1;
            end
            OP_JAL: begin
                dec_legal = 1'b1;
                dec_ctrl_raw[C_WREG]    = 1'b1;
                dec_ctrl_raw[C_JAL]     = 1'b1;
                dec_ctrl_raw[C_SIGNEXT] = 1'b1;
            end
            OP_JALR: begin
                dec_legal = (funct3 == 3'b000);
                dec_ctrl_raw[C_ALUIMM]  = 1'b1;
                dec_ctrl_raw[C_WREG]    = 1'b1;
                dec_ctrl_raw[C_JALR]    = 1'b1;
                dec_ctrl_raw[C_SIGNEXT] = 1'b1;
            end
            OP_LUI: begin
                dec_legal    = 1'b1;
                dec_aluc_raw = ALUC_LUI;
                dec_ctrl_raw[C_ALUIMM]  = 1'b1;
                dec_ctrl_raw[C_WREG]    = 1'b1;
                dec_ctrl_raw[C_SIGNEXT] = 1'b1;
            end
            OP_AUIPC: begin
                dec_legal = 1'b1;
                dec_ctrl_raw[C_ALUIMM]  = 1'b1;
                dec_ctrl_raw[C_WREG]    = 1'b1;
                dec_ctrl_raw[C_SIGNEXT] = 1'b1;
                dec_ctrl_raw[C_AUIPC]   = 1'b1;
            end
            // fence / ecall / ebreak travel as architectural no-ops.
            OP_FENCE:  dec_legal = (funct3 == 3'b000);
            OP_SYSTEM: dec_legal = (funct3 == 3'b000);
            default:   dec_legal = 1'b0;
        endcase
    end

    // An illegal slot must carry no side effects at all.
    assign dec_aluc   = dec_legal ? dec_aluc_raw   : 6'b000000;
    assign dec_ctrl   = dec_legal ? dec_ctrl_raw   : 11'b0;
    assign dec_branch = dec_legal & dec_branch_raw;
    assign dec_mop    = dec_legal & dec_mop_raw;

    // ------------------------------------------------------------------------
    // ID/EX register and mul/div sequencer
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ex_valid_q, ex_valid_d;
    logic [5:0]         aluc_q, aluc_d;
    logic [10:0]        ctrl_q, ctrl_d;
    logic               illegal_q, illegal_d;
    logic               br_q, br_d;
    logic [2:0]         br_type_q, br_type_d;
    logic               md_start_q, md_start_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_valid_d = ex_valid_q;
        aluc_d     = aluc_q;
        ctrl_d     = ctrl_q;
        illegal_d  = illegal_q;
        br_d       = br_q;
        br_type_d  = br_type_q;
        md_start_d = 1'b0;

        if (flush) begin
            // Squash wins over everything, including an in-flight mul/div.
            state_d    = S_IDLE;
            cnt_d      = '0;
            ex_valid_d = 1'b0;
            aluc_d     = '0;
            ctrl_d     = '0;
            illegal_d  = 1'b0;
            br_d       = 1'b0;
            br_type_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (id_valid) begin
                        ex_valid_d = 1'b1;
                        aluc_d     = dec_aluc;
                        ctrl_d     = dec_ctrl;
                        illegal_d  = ~dec_legal;
                        br_d       = dec_branch;
                        br_type_d  = dec_branch ? funct3 : 3'b000;
                        if (dec_mop) begin
                            md_start_d = 1'b1;
                            cnt_d      = funct3[2] ? DIV_CNT : MUL_CNT;
                            // A single-cycle unit needs no stall at all.
                            if ((funct3[2] ? DIV_CNT : MUL_CNT) != '0) begin
                                state_d = S_MD_BUSY;
                            end
                        end
                    end else begin
                        ex_valid_d = 1'b0;
                        aluc_d     = '0;
                        ctrl_d     = '0;
                        illegal_d  = 1'b0;
                        br_d       = 1'b0;
                        br_type_d  = '0;
                    end
                end
                S_MD_BUSY: begin
                    // ID/EX holds. Leave as the count reaches zero so ID
                    // resumes exactly LAT cycles after the launch.
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ex_valid_q <= 1'b0;
            aluc_q     <= '0;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
            br_q       <= 1'b0;
            br_type_q  <= '0;
            md_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            aluc_q     <= aluc_d;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
            br_q       <= br_d;
            br_type_q  <= br_type_d;
            md_start_q <= md_start_d;
        end
    end

    // ------------------------------------------------------------------------
    // EX-stage next-PC select
    // ------------------------------------------------------------------------
    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        unique case (br_type_q)
            3'b000, 3'b101, 3'b111: br_taken = z;   // beq, bge, bgeu
            3'b001, 3'b100, 3'b110: br_taken = ~z;  // bne, blt, bltu
            default:                br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pcsrc = 2'b00;
        if (ex_valid_q) begin
            if (ctrl_q[C_JAL]) begin
                pcsrc = 2'b10;
            end else if (ctrl_q[C_JALR]) begin
                pcsrc = 2'b11;
            end else if (br_q && br_taken) begin
                pcsrc = 2'b01;
            end
        end
    end

    assign id_ready = (state_q != S_MD_BUSY);
    assign md_busy  = (state_q == S_MD_BUSY);
    assign ex_valid = ex_valid_q;
    assign aluc     = aluc_q;
    assign ctrl     = ctrl_q;
    assign illegal  = illegal_q;
    assign md_start = md_start_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
`timescale 1ns/1ps
module tb_pipelined_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       id_valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       flush;
    logic       z;

    // Index 0: defaults (M on, MUL_LAT=2, DIV_LAT=32)
    // Index 1: M on, MUL_LAT=1, DIV_LAT=4
    // Index 2: M off
    logic        id_ready_w [3];
    logic        ex_valid_w [3];
    logic [5:0]  aluc_w     [3];
    logic [10:0] ctrl_w     [3];
    logic [1:0]  pcsrc_w    [3];
    logic        md_start_w [3];
    logic        md_busy_w  [3];
    logic        illegal_w  [3];

    pipelined_control_unit #(.ENABLE_M(1), .MUL_LAT(2), .DIV_LAT(32), .CNT_W(6)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .flush(flush), .z(z), .id_ready(id_ready_w[0]),
        .ex_valid(ex_valid_w[0]), .aluc(aluc_w[0]), .ctrl(ctrl_w[0]), .pcsrc(pcsrc_w[0]),
        .md_start(md_start_w[0]), .md_busy(md_busy_w[0]), .illegal(illegal_w[0]));

    pipelined_control_unit #(.ENABLE_M(1), .MUL_LAT(1), .DIV_LAT(4), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .flush(flush), .z(z), .id_ready(id_ready_w[1]),
        .ex_valid(ex_valid_w[1]), .aluc(aluc_w[1]), .ctrl(ctrl_w[1]), .pcsrc(pcsrc_w[1]),
        .md_start(md_start_w[1]), .md_busy(md_busy_w[1]), .illegal(illegal_w[1]));

    pipelined_control_unit #(.ENABLE_M(0), .MUL_LAT(2), .DIV_LAT(32), .CNT_W(6)) u_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .flush(flush), .z(z), .id_ready(id_ready_w[2]),
        .ex_valid(ex_valid_w[2]), .aluc(aluc_w[2]), .ctrl(ctrl_w[2]), .pcsrc(pcsrc_w[2]),
        .md_start(md_start_w[2]), .md_busy(md_busy_w[2]), .illegal(illegal_w[2]));

    typedef struct {
        string       tag;
        logic [5:0]  aluc;
        logic [10:0] ctrl;
        logic        ill;
        logic        start;
    } exp_t;

    exp_t sbq[$];
    int   sel   = 0;
    int   tests = 0;
    int   fails = 0;

    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPB = 7'b1100011;
    localparam logic [10:0] C_ALU = 11'b00010010000;
    localparam logic [10:0] C_BR  = 11'b00000010000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input string tag, input logic [5:0] ea, input logic [10:0] ec,
                         input logic ei, input logic es);
        exp_t e;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        id_valid = 1'b1;
        flush    = 1'b0;
        e.tag = tag; e.aluc = ea; e.ctrl = ec; e.ill = ei; e.start = es;
        sbq.push_back(e);
    endtask

    task automatic check_pop;
        exp_t e;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sbq.pop_front();
            chk({e.tag, ".ex_valid"}, 32'(ex_valid_w[sel]), 32'd1);
            chk({e.tag, ".aluc"},     32'(aluc_w[sel]),     32'(e.aluc));
            chk({e.tag, ".ctrl"},     32'(ctrl_w[sel]),     32'(e.ctrl));
            chk({e.tag, ".illegal"},  32'(illegal_w[sel]),  32'(e.ill));
            chk({e.tag, ".md_start"}, 32'(md_start_w[sel]), 32'(e.start));
        end
    endtask

    task automatic idle_inputs;
        id_valid = 1'b0;
        flush    = 1'b0;
        opcode   = 7'b0;
        funct3   = 3'b0;
        funct7   = 7'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        z = 1'b0;
        sbq.delete();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int extra;
        int hold_bad;

        // Reset values
        rst = 1'b1;
        idle_inputs();
        z = 1'b0;
        tick();
        chk("rst.ex_valid", 32'(ex_valid_w[0]), 0);
        chk("rst.aluc",     32'(aluc_w[0]),     0);
        chk("rst.ctrl",     32'(ctrl_w[0]),     0);
        chk("rst.md_start", 32'(md_start_w[0]), 0);
        chk("rst.illegal",  32'(illegal_w[0]),  0);
        chk("rst.pcsrc",    32'(pcsrc_w[0]),    0);
        chk("rst.md_busy",  32'(md_busy_w[0]),  0);
        chk("rst.id_ready", 32'(id_ready_w[0]), 1);
        rst = 1'b0;

        // Basic ALU decode
        issue(OPR, 3'b000, 7'b0000000, "add", 6'b000000, C_ALU, 1'b0, 1'b0);
        tick(); check_pop();
        issue(OPR, 3'b000, 7'b0100000, "sub", 6'b001000, C_ALU, 1'b0, 1'b0);
        tick(); check_pop();
        idle_inputs();
        tick();
        chk("bubble.ex_valid", 32'(ex_valid_w[0]), 0);
        chk("bubble.ctrl",     32'(ctrl_w[0]),     0);

        // Branch resolution
        issue(OPB, 3'b000, 7'b0, "beq", 6'b001000, C_BR, 1'b0, 1'b0);
        tick(); check_pop();
        z = 1'b1; #1 chk("beq_z1.pcsrc", 32'(pcsrc_w[0]), 1);
        z = 1'b0; #1 chk("beq_z0.pcsrc", 32'(pcsrc_w[0]), 0);
        issue(OPB, 3'b101, 7'b0, "bge", 6'b001000, C_BR, 1'b0, 1'b0);
        tick(); check_pop();
        z = 1'b1; #1 chk("bge_z1.pcsrc", 32'(pcsrc_w[0]), 1);
        issue(OPB, 3'b110, 7'b0, "bltu", 6'b001000, C_BR, 1'b0, 1'b0);
        tick(); check_pop();
        z = 1'b0; #1 chk("bltu_z0.pcsrc", 32'(pcsrc_w[0]), 1);
        issue(OPB, 3'b001, 7'b0, "bne", 6'b001000, C_BR, 1'b0, 1'b0);
        tick(); check_pop();
        z = 1'b1; #1 chk("bne_z1.pcsrc", 32'(pcsrc_w[0]), 0);
        issue(7'b1101111, 3'b000, 7'b0, "jal", 6'b000000, 11'b00011010000, 1'b0, 1'b0);
        tick(); check_pop();
        chk("jal.pcsrc", 32'(pcsrc_w[0]), 2);
        issue(7'b1100111, 3'b000, 7'b0, "jalr", 6'b000000, 11'b00110110000, 1'b0, 1'b0);
        tick(); check_pop();
        chk("jalr.pcsrc", 32'(pcsrc_w[0]), 3);
        issue(7'b0000011, 3'b000, 7'b0, "lb", 6'b000000, 11'b10110010101, 1'b0, 1'b0);
        tick(); check_pop();
        issue(7'b0100011, 3'b001, 7'b0, "sh", 6'b000000, 11'b01100010010, 1'b0, 1'b0);
        tick(); check_pop();
        idle_inputs();
        tick();
        chk("bubble_z1.pcsrc", 32'(pcsrc_w[0]), 0);

        // Divide, DIV_LAT=32: 31 stall cycles with ID/EX held
        issue(OPR, 3'b100, 7'b0000001, "div", 6'b001001, C_ALU, 1'b0, 1'b1);
        tick(); check_pop();
        chk("div.id_ready", 32'(id_ready_w[0]), 0);
        chk("div.md_busy",  32'(md_busy_w[0]),  1);
        opcode = OPR; funct3 = 3'b000; funct7 = 7'b0; id_valid = 1'b1;
        low = 1; extra = 0; hold_bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (id_ready_w[0]) break;
            low++;
            if (md_start_w[0]) extra++;
            if (aluc_w[0] !== 6'b001001) hold_bad++;
        end
        chk("div.stall_cycles", 32'(low), 31);
        chk("div.extra_start",  32'(extra), 0);
        chk("div.hold_aluc",    32'(hold_bad), 0);
        issue(OPR, 3'b000, 7'b0000000, "add_after_div", 6'b000000, C_ALU, 1'b0, 1'b0);
        tick(); check_pop();
        issue(OPR, 3'b000, 7'b0000001, "mul_lat2", 6'b000001, C_ALU, 1'b0, 1'b1);
        tick(); check_pop();
        chk("mul_lat2.id_ready", 32'(id_ready_w[0]), 0);
        idle_inputs();
        tick();
        chk("mul_lat2.id_ready_after", 32'(id_ready_w[0]), 1);
        chk("mul_lat2.start_after",    32'(md_start_w[0]), 0);

        // MUL_LAT=1: no stall, back-to-back issue
        sel = 1;
        do_reset();
        issue(OPR, 3'b000, 7'b0000001, "mul1", 6'b000001, C_ALU, 1'b0, 1'b1);
        tick(); check_pop();
        chk("mul1.id_ready", 32'(id_ready_w[1]), 1);
        chk("mul1.md_busy",  32'(md_busy_w[1]),  0);
        issue(OPR, 3'b000, 7'b0000000, "add_b2b", 6'b000000, C_ALU, 1'b0, 1'b0);
        tick(); check_pop();
        issue(OPR, 3'b000, 7'b0000001, "mul_b2b_a", 6'b000001, C_ALU, 1'b0, 1'b1);
        tick(); check_pop();
        issue(OPR, 3'b001, 7'b0000001, "mulh_b2b_b", 6'b010001, C_ALU, 1'b0, 1'b1);
        tick(); check_pop();
        chk("mulh_b2b.id_ready", 32'(id_ready_w[1]), 1);
        idle_inputs();

        // Flush on cycle 5 of a divide
        sel = 0;
        do_reset();
        issue(OPR, 3'b100, 7'b0000001, "div_fl", 6'b001001, C_ALU, 1'b0, 1'b1);
        tick(); check_pop();
        idle_inputs();
        repeat (3) tick();
        opcode = OPR; funct3 = 3'b000; funct7 = 7'b0000001; id_valid = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush.ex_valid", 32'(ex_valid_w[0]), 0);
        chk("flush.md_busy",  32'(md_busy_w[0]),  0);
        chk("flush.id_ready", 32'(id_ready_w[0]), 1);
        chk("flush.md_start", 32'(md_start_w[0]), 0);
        chk("flush.ctrl",     32'(ctrl_w[0]),     0);
        chk("flush.aluc",     32'(aluc_w[0]),     0);
        idle_inputs();
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (md_start_w[0]) extra++;
        end
        chk("flush.no_start_after", 32'(extra), 0);
        // Flush together with an M-op in IDLE: nothing launches
        opcode = OPR; funct3 = 3'b000; funct7 = 7'b0000001; id_valid = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush_mop.md_start", 32'(md_start_w[0]), 0);
        chk("flush_mop.ex_valid", 32'(ex_valid_w[0]), 0);
        chk("flush_mop.md_busy",  32'(md_busy_w[0]),  0);
        idle_inputs();

        // Asynchronous reset in the middle of a divide
        issue(OPR, 3'b100, 7'b0000001, "div_rst", 6'b001001, C_ALU, 1'b0, 1'b1);
        tick(); check_pop();
        idle_inputs();
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst.ex_valid", 32'(ex_valid_w[0]), 0);
        chk("arst.md_busy",  32'(md_busy_w[0]),  0);
        chk("arst.id_ready", 32'(id_ready_w[0]), 1);
        chk("arst.aluc",     32'(aluc_w[0]),     0);
        tick();
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (md_start_w[0]) extra++;
        end
        chk("arst.no_start_after", 32'(extra), 0);

        // Illegal encodings
        issue(7'b1111111, 3'b000, 7'b0, "ill_opcode", 6'b000000, 11'b0, 1'b1, 1'b0);
        tick(); check_pop();
        z = 1'b1; #1 chk("ill_opcode.pcsrc", 32'(pcsrc_w[0]), 0);
        issue(OPR, 3'b000, 7'b0000000, "add_clears_ill", 6'b000000, C_ALU, 1'b0, 1'b0);
        tick(); check_pop();
        issue(OPR, 3'b001, 7'b0100000, "ill_f7", 6'b000000, 11'b0, 1'b1, 1'b0);
        tick(); check_pop();
        issue(OPB, 3'b010, 7'b0, "ill_br_f3", 6'b000000, 11'b0, 1'b1, 1'b0);
        tick(); check_pop();
        chk("ill_br_f3.pcsrc", 32'(pcsrc_w[0]), 0);

        // ENABLE_M=0: mul is illegal and never launches
        sel = 2;
        do_reset();
        issue(OPR, 3'b000, 7'b0000001, "mul_noM", 6'b000000, 11'b0, 1'b1, 1'b0);
        tick(); check_pop();
        chk("mul_noM.md_busy",  32'(md_busy_w[2]),  0);
        chk("mul_noM.id_ready", 32'(id_ready_w[2]), 1);
        issue(OPR, 3'b000, 7'b0000000, "add_noM", 6'b000000, C_ALU, 1'b0, 1'b0);
        tick(); check_pop();
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
